// File: rtl/fp_round_pack_if.sv
// Operand/result handshake bundle for fp_round_pack: valid/ready on both sides.
// slave = rounding stage, master = upstream normalizer plus downstream consumer.
interface fp_round_pack_if;
  logic        in_valid;
  logic        in_ready;
  logic        mode_fp;
  logic        sign;
  logic [48:0] mant;
  logic [8:0]  exp;
  logic [4:0]  flags_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [4:0]  flags;

  modport slave (
    input  in_valid, mode_fp, sign, mant, exp, flags_in, out_ready,
    output in_ready, out_valid, result, flags
  );

  modport master (
    output in_valid, mode_fp, sign, mant, exp, flags_in, out_ready,
    input  in_ready, out_valid, result, flags
  );
endinterface

// File: rtl/fp_round_pack.sv
// RNE rounding and IEEE-754 packing (half/single); 2-cycle latency, one op per clock.
// Output held while out_valid & !out_ready; in_ready drops only when both stages are full and stalled.
module fp_round_pack #(
  parameter bit FLUSH_SUBNORMAL = 1'b0
) (
  input logic clk,
  input logic rst,
  fp_round_pack_if.slave bus
);

  localparam logic [9:0]  MAX_SINGLE = 10'd254;
  localparam logic [9:0]  MAX_HALF   = 10'd30;
  localparam logic [31:0] QNAN_SINGLE = 32'h7FC0_0000;
  localparam logic [31:0] QNAN_HALF   = 32'h0000_7E00;
  localparam logic [31:0] INF_SINGLE  = 32'h7F80_0000;
  localparam logic [31:0] INF_HALF    = 32'h0000_7C00;

  logic        s1_valid, s2_valid, s2_adv, in_fire;
  logic        s1_mode, s1_sign, s1_inexact, s1_zero;
  logic [24:0] s1_sig;
  logic [8:0]  s1_exp;
  logic [4:0]  s1_flags;
  logic [31:0] res_q;
  logic [4:0]  flg_q;

  assign s2_adv       = !s2_valid || bus.out_ready;
  assign bus.in_ready = !s1_valid || s2_adv;
  assign in_fire      = bus.in_valid && bus.in_ready;
  assign bus.out_valid = s2_valid;
  assign bus.result    = res_q;
  assign bus.flags     = flg_q;

  // Stage 1: split fields by precision and apply round-to-nearest-even.
  logic        g_bit, s_bit, l_bit, inc;
  logic [24:0] base, sig_rnd;

  always_comb begin
    base  = '0;
    g_bit = 1'b0;
    s_bit = 1'b0;
    l_bit = 1'b0;
    if (bus.mode_fp) begin
      base  = {1'b0, bus.mant[47:24]};
      g_bit = bus.mant[23];
      s_bit = |bus.mant[22:0];
      l_bit = bus.mant[24];
    end else begin
      base  = {14'b0, bus.mant[47:37]};
      g_bit = bus.mant[36];
      s_bit = |bus.mant[35:0];
      l_bit = bus.mant[37];
    end
    inc     = g_bit && (s_bit || l_bit);
    sig_rnd = base + {24'b0, inc};
  end

  // Stage 2: renormalize a rounding carry, then classify and pack.
  logic        carry, hidden;
  logic [23:0] sig_adj;
  logic [9:0]  exp_adj, exp_max;
  logic [31:0] signed_zero, res_n;
  logic [4:0]  flg_n;

  always_comb begin
    carry       = s1_mode ? s1_sig[24] : s1_sig[11];
    sig_adj     = carry ? s1_sig[24:1] : s1_sig[23:0];
    exp_adj     = {1'b0, s1_exp} + {9'b0, carry};
    hidden      = s1_mode ? sig_adj[23] : sig_adj[10];
    exp_max     = s1_mode ? MAX_SINGLE : MAX_HALF;
    signed_zero = s1_mode ? {s1_sign, 31'b0} : {16'b0, s1_sign, 15'b0};
    flg_n       = {s1_flags[4:1], s1_flags[0] | s1_inexact};
    res_n       = s1_mode ? {s1_sign, exp_adj[7:0], sig_adj[22:0]}
                          : {16'b0, s1_sign, exp_adj[4:0], sig_adj[9:0]};
    if (s1_flags[1]) begin
      res_n = s1_mode ? QNAN_SINGLE : QNAN_HALF;
    end else if (s1_zero) begin
      res_n = signed_zero;
      flg_n = {2'b00, s1_flags[2:1], 1'b0};
    end else if (exp_adj > exp_max) begin
      res_n    = signed_zero | (s1_mode ? INF_SINGLE : INF_HALF);
      flg_n[4] = 1'b1;
      flg_n[0] = 1'b1;
    end else if (exp_adj == 10'd0) begin
      res_n    = signed_zero;
      flg_n[3] = 1'b1;
    end else if (!hidden) begin
      if (FLUSH_SUBNORMAL) begin
        res_n    = signed_zero;
        flg_n[3] = 1'b1;
      end else begin
        res_n    = s1_mode ? {s1_sign, 8'b0, sig_adj[22:0]}
                           : {16'b0, s1_sign, 5'b0, sig_adj[9:0]};
        flg_n[3] = flg_n[3] | s1_inexact;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s2_valid   <= 1'b0;
      s1_mode    <= 1'b0;
      s1_sign    <= 1'b0;
      s1_inexact <= 1'b0;
      s1_zero    <= 1'b0;
      s1_sig     <= '0;
      s1_exp     <= '0;
      s1_flags   <= '0;
      res_q      <= '0;
      flg_q      <= '0;
    end else begin
      s1_valid <= in_fire || (s1_valid && !s2_adv);
      if (in_fire) begin
        s1_mode    <= bus.mode_fp;
        s1_sign    <= bus.sign;
        s1_inexact <= g_bit || s_bit;
        s1_zero    <= (bus.mant == 49'd0);
        s1_sig     <= sig_rnd;
        s1_exp     <= bus.exp;
        s1_flags   <= bus.flags_in;
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          res_q <= res_n;
          flg_q <= flg_n;
        end
      end
    end
  end

endmodule

// File: tb/tb_fp_round_pack.sv
// Bench for fp_round_pack: directed corner cases, random ops under random stalls, and reset mid-flight.
// Two instances (subnormals kept / flushed) see identical stimulus.
module tb_fp_round_pack;

  typedef struct {
    logic        mode;
    logic        sign;
    logic [48:0] mant;
    logic [8:0]  exp;
    logic [4:0]  fin;
    bit          fixed;
    logic [31:0] r0;
    logic [4:0]  f0;
    logic [31:0] r1;
    logic [4:0]  f1;
  } op_t;

  typedef struct {
    logic [31:0] r0;
    logic [4:0]  f0;
    logic [31:0] r1;
    logic [4:0]  f1;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp_round_pack_if bus0();
  fp_round_pack_if bus1();

  fp_round_pack #(.FLUSH_SUBNORMAL(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  fp_round_pack #(.FLUSH_SUBNORMAL(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t q[$];
  op_t  dir[10];
  op_t  idle_op;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference: integer-domain rounding of the kept bits, then IEEE classification.
  function automatic void model(input op_t o, input bit flush,
                                output logic [31:0] r, output logic [4:0] f);
    int fw, sh, mx, e;
    logic [63:0] m, kept, rem, halfp, sgn;
    bit inx;
    fw = o.mode ? 23 : 10;
    sh = o.mode ? 24 : 37;
    mx = o.mode ? 254 : 30;
    m = 64'(o.mant[47:0]);
    kept = m >> sh;
    rem = m & ((64'd1 << sh) - 64'd1);
    halfp = 64'd1 << (sh - 1);
    if (rem > halfp || (rem == halfp && kept[0])) kept = kept + 64'd1;
    inx = (rem != 64'd0);
    e = int'(o.exp);
    if (kept >= (64'd1 << (fw + 1))) begin
      kept = kept >> 1;
      e = e + 1;
    end
    sgn = o.sign ? (o.mode ? 64'h8000_0000 : 64'h8000) : 64'd0;
    f = o.fin;
    f[0] = f[0] | inx;
    if (o.fin[1]) begin
      r = o.mode ? 32'h7FC0_0000 : 32'h0000_7E00;
    end else if (o.mant == 49'd0) begin
      r = 32'(sgn);
      f = {2'b00, o.fin[2:1], 1'b0};
    end else if (e > mx) begin
      r = 32'(sgn | (o.mode ? 64'h7F80_0000 : 64'h7C00));
      f[4] = 1'b1;
      f[0] = 1'b1;
    end else if (e == 0) begin
      r = 32'(sgn);
      f[3] = 1'b1;
    end else if ((kept >> fw) == 64'd0) begin
      if (flush) begin
        r = 32'(sgn);
        f[3] = 1'b1;
      end else begin
        r = 32'(sgn | kept);
        f[3] = f[3] | inx;
      end
    end else begin
      r = 32'(sgn | (64'(e) << fw) | (kept & ((64'd1 << fw) - 64'd1)));
    end
  endfunction

  function automatic op_t dop(input logic mode, input logic sign, input logic [48:0] mant,
                              input logic [8:0] exp, input logic [4:0] fin,
                              input logic [31:0] r0, input logic [4:0] f0,
                              input logic [31:0] r1, input logic [4:0] f1);
    op_t o;
    o.mode = mode; o.sign = sign; o.mant = mant; o.exp = exp; o.fin = fin;
    o.fixed = 1'b1; o.r0 = r0; o.f0 = f0; o.r1 = r1; o.f1 = f1;
    return o;
  endfunction

  function automatic op_t rop();
    op_t o;
    o = idle_op;
    o.fixed = 1'b0;
    o.mode = 1'($urandom_range(0, 1));
    o.sign = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 3))
      0:       o.exp = o.mode ? 9'($urandom_range(250, 256)) : 9'($urandom_range(28, 32));
      1:       o.exp = 9'($urandom_range(0, 2));
      default: o.exp = o.mode ? 9'($urandom_range(1, 254)) : 9'($urandom_range(1, 30));
    endcase
    o.mant = {1'b0, 1'b1, 47'({$urandom, $urandom})};
    if (o.exp <= 9'd1 && $urandom_range(0, 1) == 1) o.mant[47] = 1'b0;
    // Exact ties and near-ties exercise the even rule.
    if ($urandom_range(0, 3) == 0) begin
      if (o.mode) o.mant[22:0] = '0;
      else        o.mant[35:0] = '0;
    end
    if ($urandom_range(0, 15) == 0) o.mant = '0;
    o.fin = 5'($urandom);
    if ($urandom_range(0, 7) != 0) o.fin[1] = 1'b0;
    return o;
  endfunction

  task automatic drive(input logic iv, input op_t o, input logic ordy);
    bus0.in_valid = iv;   bus1.in_valid = iv;
    bus0.mode_fp  = o.mode; bus1.mode_fp = o.mode;
    bus0.sign     = o.sign; bus1.sign    = o.sign;
    bus0.mant     = o.mant; bus1.mant    = o.mant;
    bus0.exp      = o.exp;  bus1.exp     = o.exp;
    bus0.flags_in = o.fin;  bus1.flags_in = o.fin;
    bus0.out_ready = ordy;  bus1.out_ready = ordy;
  endtask

  task automatic step(input logic iv, input op_t o, input logic ordy, output bit accepted);
    exp_t e;
    logic rdy_exp, ov_exp;
    drive(iv, o, ordy);
    @(negedge clk);
    rdy_exp = !(q.size() == 2 && !ordy);
    ov_exp = 1'b0;
    if (q.size() > 0) ov_exp = (cyc >= q[0].acc + 2);
    chk("in_ready0", 32'(bus0.in_ready), 32'(rdy_exp));
    chk("in_ready1", 32'(bus1.in_ready), 32'(rdy_exp));
    chk("out_valid0", 32'(bus0.out_valid), 32'(ov_exp));
    chk("out_valid1", 32'(bus1.out_valid), 32'(ov_exp));
    if (ov_exp) begin
      chk("result0", bus0.result, q[0].r0);
      chk("flags0", 32'(bus0.flags), 32'(q[0].f0));
      chk("result1", bus1.result, q[0].r1);
      chk("flags1", 32'(bus1.flags), 32'(q[0].f1));
      if (ordy) void'(q.pop_front());
    end
    accepted = iv && rdy_exp;
    if (accepted) begin
      if (o.fixed) begin
        e.r0 = o.r0; e.f0 = o.f0; e.r1 = o.r1; e.f1 = o.f1;
      end else begin
        model(o, 1'b0, e.r0, e.f0);
        model(o, 1'b1, e.r1, e.f1);
      end
      e.acc = cyc;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int  idx, k, n;
    bit  acc;
    idle_op = '{mode: 1'b0, sign: 1'b0, mant: '0, exp: '0, fin: '0, fixed: 1'b0,
                r0: '0, f0: '0, r1: '0, f1: '0};

    dir[0] = dop(1, 0, {1'b0, 24'h800000, 1'b1, 23'b0}, 9'd127, 5'd0,
                 32'h3F80_0000, 5'b00001, 32'h3F80_0000, 5'b00001);
    dir[1] = dop(1, 0, {1'b0, 24'hFFFFFF, 1'b1, 23'b0}, 9'd127, 5'd0,
                 32'h4000_0000, 5'b00001, 32'h4000_0000, 5'b00001);
    dir[2] = dop(0, 0, {1'b0, 11'h7FF, 1'b1, 36'b0}, 9'd30, 5'd0,
                 32'h0000_7C00, 5'b10001, 32'h0000_7C00, 5'b10001);
    dir[3] = dop(0, 0, {1'b0, 1'b0, 10'h155, 37'b0}, 9'd1, 5'd0,
                 32'h0000_0155, 5'b00000, 32'h0000_0000, 5'b01000);
    dir[4] = dop(1, 0, {1'b0, 24'hC00000, 24'b0}, 9'd127, 5'b00010,
                 32'h7FC0_0000, 5'b00010, 32'h7FC0_0000, 5'b00010);
    dir[5] = dop(0, 1, 49'd0, 9'd15, 5'b10101,
                 32'h0000_8000, 5'b00100, 32'h0000_8000, 5'b00100);
    dir[6] = dop(1, 0, {1'b0, 24'h800000, 24'b0}, 9'd0, 5'd0,
                 32'h0000_0000, 5'b01000, 32'h0000_0000, 5'b01000);
    dir[7] = dop(1, 1, {1'b0, 24'h800000, 24'b0}, 9'd255, 5'd0,
                 32'hFF80_0000, 5'b10001, 32'hFF80_0000, 5'b10001);
    dir[8] = dop(0, 0, {1'b0, 1'b0, 10'h3FF, 1'b1, 36'b0}, 9'd1, 5'd0,
                 32'h0000_0400, 5'b00001, 32'h0000_0400, 5'b00001);
    dir[9] = dop(0, 0, {1'b0, 1'b0, 10'h001, 1'b0, 35'b0, 1'b1}, 9'd1, 5'd0,
                 32'h0000_0001, 5'b01001, 32'h0000_0000, 5'b01001);

    rst = 1'b1;
    drive(1'b0, idle_op, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_out_valid", 32'(bus0.out_valid), 32'd0);
    chk("rst_result", bus0.result, 32'd0);
    chk("rst_flags", 32'(bus0.flags), 32'd0);
    chk("rst_in_ready", 32'(bus0.in_ready), 32'd1);

    // Directed ops back to back, with a 3-cycle downstream stall mid-stream.
    idx = 0;
    k = 0;
    while ((idx < 10 || q.size() > 0) && k < 300) begin
      step(idx < 10, dir[(idx < 10) ? idx : 0], !(k >= 3 && k < 6), acc);
      if (acc) idx++;
      k++;
    end
    if (k >= 300) chk("directed_timeout", 32'(idx), 32'd10);

    // Random ops with random valid and ready.
    n = 0;
    k = 0;
    begin
      op_t cur;
      cur = rop();
      while ((n < 400 || q.size() > 0) && k < 4000) begin
        step(n < 400 && $urandom_range(0, 9) < 7, cur, $urandom_range(0, 9) < 7, acc);
        if (acc) begin
          n++;
          cur = rop();
        end
        k++;
      end
    end
    if (k >= 4000) chk("random_timeout", 32'(n), 32'd400);

    // Fill both stages, then reset with an accept pending in the same cycle.
    repeat (3) step(1'b1, rop(), 1'b0, acc);
    drive(1'b1, rop(), 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b0, idle_op, 1'b1);
    q.delete();
    cyc++;
    chk("midrst_out_valid0", 32'(bus0.out_valid), 32'd0);
    chk("midrst_out_valid1", 32'(bus1.out_valid), 32'd0);
    chk("midrst_result0", bus0.result, 32'd0);
    chk("midrst_flags0", 32'(bus0.flags), 32'd0);
    chk("midrst_in_ready", 32'(bus0.in_ready), 32'd1);
    repeat (4) step(1'b0, idle_op, 1'b1, acc);

    // Pipe still works after the flush.
    step(1'b1, dir[0], 1'b1, acc);
    k = 0;
    while (q.size() > 0 && k < 20) begin
      step(1'b0, idle_op, 1'b1, acc);
      k++;
    end
    if (k >= 20) chk("post_reset_timeout", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
